dl_pass_writer: RTL

Password enrollment block for the digital lock. It owns the stored password register and is the writer side of the password interface that the lock FSM reads. While the lock is unlocked and programming mode is selected, the user enters a new password digit-by-digit on the switches, then re-enters it. The register is overwritten only when both entries match.

---
 rtl/dl_pkg.sv | 34 +++
 rtl/dl_pass_writer_if.sv | 21 ++
 rtl/dl_key_sync.sv | 23 ++
 rtl/dl_pass_writer.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/dl_pkg.sv
// Shared digital-lock definitions: digit width, BCD limit, password-writer states and phases.
package dl_pkg;

    localparam int unsigned DL_DIGIT_W = 4;
    localparam logic [DL_DIGIT_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [2:0] {
        PW_IDLE   = 3'd0,
        PW_ENTER1 = 3'd1,
        PW_ENTER2 = 3'd2,
        PW_CHECK  = 3'd3,
        PW_RESULT = 3'd4
    } pw_state_t;

    localparam logic [1:0] PH_IDLE   = 2'd0;
    localparam logic [1:0] PH_ENTER1 = 2'd1;
    localparam logic [1:0] PH_ENTER2 = 2'd2;
    localparam logic [1:0] PH_RESULT = 2'd3;

    // CHECK lasts one cycle and is still reported as the second entry.
    function automatic logic [1:0] pw_phase(pw_state_t s);
        logic [1:0] ph;
        ph = PH_IDLE;
        case (s)
            PW_ENTER1: ph = PH_ENTER1;
            PW_ENTER2: ph = PH_ENTER2;
            PW_CHECK:  ph = PH_ENTER2;
            PW_RESULT: ph = PH_RESULT;
            default:   ph = PH_IDLE;
        endcase
        return ph;
    endfunction

endpackage

// File: rtl/dl_pass_writer_if.sv
// Password interface between the enrollment writer (master) and the lock FSM (slave).
interface dl_pass_writer_if
    import dl_pkg::*;
#(
    parameter int unsigned DIGITS = 3
);
    logic [DL_DIGIT_W*DIGITS-1:0] o_password;
    logic                         o_busy;
    logic [1:0]                   o_digit_cnt;
    logic [1:0]                   o_phase;
    logic                         o_done;
    logic                         o_mismatch;

    modport master (
        output o_password, o_busy, o_digit_cnt, o_phase, o_done, o_mismatch
    );

    modport slave (
        input o_password, o_busy, o_digit_cnt, o_phase, o_done, o_mismatch
    );
endinterface

// File: rtl/dl_key_sync.sv
// Two-flop synchronizer for an active-low key with a one-cycle press pulse on its falling edge.
module dl_key_sync (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_key_n,
    output logic o_press
);
    logic sync1_q, sync2_q, dly_q;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            dly_q   <= 1'b1;
        end else begin
            sync1_q <= i_key_n;
            sync2_q <= sync1_q;
            dly_q   <= sync2_q;
        end
    end

    assign o_press = dly_q & ~sync2_q;
endmodule

// File: rtl/dl_pass_writer.sv
// Password enrollment: double entry of DIGITS BCD digits, committed only when both match.
// Optional inactivity timeout during entry is enabled by defining DL_PW_TIMEOUT_EN.
module dl_pass_writer
    import dl_pkg::*;
#(
    parameter int unsigned                  DIGITS         = 3,
    parameter logic [DL_DIGIT_W*DIGITS-1:0] DEFAULT_PASS   = 12'h123,
    parameter int unsigned                  TIMEOUT_CYCLES = 500_000_000
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [DL_DIGIT_W-1:0] i_digit,
    input  logic                  i_confirm_n,
    input  logic                  i_prog,
    input  logic                  i_unlocked,
    dl_pass_writer_if.master      pw
);
    localparam int unsigned PW   = DL_DIGIT_W * DIGITS;
    localparam logic [1:0]  LAST = 2'(DIGITS - 1);

    pw_state_t   state_q, state_d;
    logic [PW-1:0] buf_a_q, buf_a_d, buf_b_q, buf_b_d, pass_q, pass_d;
    logic [1:0]  cnt_q, cnt_d, phase_q;
    logic        mism_q, mism_d, done_q, done_d, busy_q;
    logic        press, keep, valid_digit, timeout;

    dl_key_sync u_confirm_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_key_n (i_confirm_n),
        .o_press (press)
    );

    assign keep        = i_prog & i_unlocked;
    assign valid_digit = press && (i_digit <= BCD_MAX);

`ifdef DL_PW_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmr_q;
    logic          in_entry;

    assign in_entry = (state_q == PW_ENTER1) || (state_q == PW_ENTER2);
    assign timeout  = in_entry && (tmr_q == TW'(TIMEOUT_CYCLES));

    // Reloads on reset, outside entry, on any press and on every state change.
    always_ff @(posedge i_clk) begin
        if (!i_reset || !in_entry || press || (state_d != state_q)) begin
            tmr_q <= '0;
        end else if (!timeout) begin
            tmr_q <= tmr_q + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_a_d = buf_a_q;
        buf_b_d = buf_b_q;
        pass_d  = pass_q;
        mism_d  = mism_q;
        done_d  = 1'b0;
        unique case (state_q)
            PW_IDLE: begin
                if (keep) begin
                    state_d = PW_ENTER1;
                    mism_d  = 1'b0;
                end
            end
            PW_ENTER1: begin
                if (!keep) begin
                    state_d = PW_IDLE;
                end else if (timeout) begin
                    state_d = PW_RESULT;
                    mism_d  = 1'b1;
                end else if (valid_digit) begin
                    buf_a_d[DL_DIGIT_W*cnt_q +: DL_DIGIT_W] = i_digit;
                    if (cnt_q == LAST) begin
                        state_d = PW_ENTER2;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            PW_ENTER2: begin
                if (!keep) begin
                    state_d = PW_IDLE;
                end else if (timeout) begin
                    state_d = PW_RESULT;
                    mism_d  = 1'b1;
                end else if (valid_digit) begin
                    buf_b_d[DL_DIGIT_W*cnt_q +: DL_DIGIT_W] = i_digit;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == LAST) begin
                        state_d = PW_CHECK;
                    end
                end
            end
            PW_CHECK: begin
                if (!keep) begin
                    state_d = PW_IDLE;
                end else begin
                    state_d = PW_RESULT;
                    if (buf_a_q == buf_b_q) begin
                        pass_d = buf_a_q;
                        done_d = 1'b1;
                    end else begin
                        mism_d = 1'b1;
                    end
                end
            end
            PW_RESULT: begin
                if (!i_prog) begin
                    state_d = PW_IDLE;
                end
            end
            default: state_d = PW_IDLE;
        endcase
        if (state_d == PW_IDLE) begin
            cnt_d = '0;
        end
    end

    // Status outputs are registered from the next state so they track the state register.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q <= PW_IDLE;
            cnt_q   <= '0;
            buf_a_q <= '0;
            buf_b_q <= '0;
            pass_q  <= DEFAULT_PASS;
            mism_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            phase_q <= PH_IDLE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_a_q <= buf_a_d;
            buf_b_q <= buf_b_d;
            pass_q  <= pass_d;
            mism_q  <= mism_d;
            done_q  <= done_d;
            busy_q  <= (state_d == PW_ENTER1) || (state_d == PW_ENTER2) ||
                       (state_d == PW_CHECK);
            phase_q <= pw_phase(state_d);
        end
    end

    assign pw.o_password  = pass_q;
    assign pw.o_busy      = busy_q;
    assign pw.o_digit_cnt = cnt_q;
    assign pw.o_phase     = phase_q;
    assign pw.o_done      = done_q;
    assign pw.o_mismatch  = mism_q;
endmodule
